// File: rtl/rdc_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : rdc_event_logger
// Description : Logs every newly raised bit of the RDC sticky interruption
//               vector into a FIFO of {timestamp, event index, watermark}
//               entries, drained through a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module rdc_event_logger #(
   parameter int N_CORES       = 4,
   parameter int CORE_EVENTS   = 2,
   parameter int WEIGHTS_WIDTH = 8,
   parameter int TS_WIDTH      = 32,
   parameter int FIFO_DEPTH    = 8,
   parameter int OVF_WIDTH     = 8
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        enable_i,
   input  logic                                        clear_i,
   input  logic [N_CORES*CORE_EVENTS-1:0]              interruption_vector_i,
   input  logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0] watermark_i,
   output logic                                        entry_valid_o,
   input  logic                                        entry_ready_i,
   output logic [TS_WIDTH-1:0]                         entry_timestamp_o,
   output logic [$clog2(N_CORES*CORE_EVENTS)-1:0]      entry_index_o,
   output logic [WEIGHTS_WIDTH-1:0]                    entry_watermark_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]             fifo_count_o,
   output logic [OVF_WIDTH-1:0]                        overflow_count_o,
   output logic                                        pending_o
);

   localparam int N_EVENTS = N_CORES * CORE_EVENTS;
   localparam int IDX_W    = $clog2(N_EVENTS);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0]        c_FIFO_FULL = CW'(FIFO_DEPTH);
   localparam logic [OVF_WIDTH-1:0] c_OVF_MAX   = '1;

   // Event tracking state
   logic [TS_WIDTH-1:0]      r_ts;
   logic [N_EVENTS-1:0]      r_prev_vec;
   logic [N_EVENTS-1:0]      r_pending;
   logic [OVF_WIDTH-1:0]     r_ovf_cnt;

   // Log FIFO storage and bookkeeping
   logic [TS_WIDTH-1:0]      r_mem_ts [FIFO_DEPTH];
   logic [IDX_W-1:0]         r_mem_idx [FIFO_DEPTH];
   logic [WEIGHTS_WIDTH-1:0] r_mem_wm [FIFO_DEPTH];
   logic [AW-1:0]            r_wr_ptr;
   logic [AW-1:0]            r_rd_ptr;
   logic [CW-1:0]            r_count;

   // Combinational control
   logic [N_EVENTS-1:0]      w_new_bits;
   logic                     w_grant_valid;
   logic [IDX_W-1:0]         w_grant_idx;
   logic                     w_grant;
   logic [N_EVENTS-1:0]      w_grant_mask;
   logic [WEIGHTS_WIDTH-1:0] w_wm_slice [N_EVENTS];
   logic [WEIGHTS_WIDTH-1:0] w_grant_wm;
   logic                     w_valid;
   logic                     w_full;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_drop;

   // Unpack the flattened watermark bus into per-event slices
   for (genvar k = 0; k < N_EVENTS; k++) begin : g_wm_slice
      assign w_wm_slice[k] = watermark_i[k*WEIGHTS_WIDTH +: WEIGHTS_WIDTH];
   end

   assign w_new_bits = interruption_vector_i & ~r_prev_vec;

   // Lowest-index priority pick over the registered pending mask only
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      for (int k = N_EVENTS - 1; k >= 0; k--) begin
         if (r_pending[k]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = k[IDX_W-1:0];
         end
      end
   end

   // A grant only happens in normal, enabled operation; reset/clear discard it
   assign w_grant      = w_grant_valid & enable_i & ~clear_i & ~rst_i;
   assign w_grant_mask = w_grant ? (N_EVENTS'(1) << w_grant_idx) : '0;
   assign w_grant_wm   = w_wm_slice[w_grant_idx];

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == c_FIFO_FULL);
   assign w_pop   = w_valid & entry_ready_i & ~clear_i & ~rst_i;
   // A full FIFO still accepts the entry when the head leaves in the same cycle
   assign w_push  = w_grant & (~w_full | w_pop);
   assign w_drop  = w_grant & w_full & ~w_pop;

   // Timestamp, edge detection, pending mask and overflow counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ts       <= '0;
         r_prev_vec <= '0;
         r_pending  <= '0;
         r_ovf_cnt  <= '0;
      end else if (clear_i) begin
         r_ts       <= '0;
         r_prev_vec <= interruption_vector_i;
         r_pending  <= '0;
         r_ovf_cnt  <= '0;
      end else begin
         if (enable_i) begin
            r_ts       <= r_ts + 1'b1;
            r_prev_vec <= interruption_vector_i;
            r_pending  <= (r_pending | w_new_bits) & ~w_grant_mask;
         end else begin
            // The RDC drops its vector on disable, so start from a clean slate
            r_prev_vec <= '0;
            r_pending  <= '0;
         end
         if (w_drop && (r_ovf_cnt != c_OVF_MAX)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents beyond the occupancy are never observed
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_ts[r_wr_ptr]  <= r_ts;
         r_mem_idx[r_wr_ptr] <= w_grant_idx;
         r_mem_wm[r_wr_ptr]  <= w_grant_wm;
      end
   end

   // Head fields are forced to zero while empty so reset shows all-zero outputs
   assign entry_valid_o     = w_valid;
   assign entry_timestamp_o = w_valid ? r_mem_ts[r_rd_ptr]  : '0;
   assign entry_index_o     = w_valid ? r_mem_idx[r_rd_ptr] : '0;
   assign entry_watermark_o = w_valid ? r_mem_wm[r_rd_ptr]  : '0;
   assign fifo_count_o      = r_count;
   assign overflow_count_o  = r_ovf_cnt;
   assign pending_o         = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rdc_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_rdc_event_logger
// Description : Self-checking bench for rdc_event_logger: directed scenarios,
//               a vector table and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rdc_event_logger;

   localparam int NEV   = 8;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, en, clr, rdy;
   logic [7:0]  vec;
   logic [63:0] wm;
   logic        valid_o, pending_o;
   logic [31:0] ts_o;
   logic [2:0]  idx_o;
   logic [7:0]  wm_o;
   logic [3:0]  count_o;
   logic [7:0]  ovf_o;

   int n_checks = 0;
   int n_fail   = 0;

   rdc_event_logger dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .enable_i              (en),
      .clear_i               (clr),
      .interruption_vector_i (vec),
      .watermark_i           (wm),
      .entry_valid_o         (valid_o),
      .entry_ready_i         (rdy),
      .entry_timestamp_o     (ts_o),
      .entry_index_o         (idx_o),
      .entry_watermark_o     (wm_o),
      .fifo_count_o          (count_o),
      .overflow_count_o      (ovf_o),
      .pending_o             (pending_o)
   );

   always #5 clk = ~clk;

   // Behavioural reference: a queue of log entries plus a set of waiting events
   typedef struct {
      logic [31:0] ts;
      int          idx;
      logic [7:0]  wm;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_ts;
   logic [7:0]  m_prev, m_pend;
   int          m_ovf;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] slice_of(input int k);
      logic [63:0] w;
      w = wm;
      return w[k*8 +: 8];
   endfunction

   function automatic void model_step();
      int         g;
      logic [7:0] nb;
      ent_t       e;
      if (rst) begin
         q.delete(); m_ts = 0; m_prev = 0; m_pend = 0; m_ovf = 0;
      end else if (clr) begin
         q.delete(); m_ts = 0; m_pend = 0; m_ovf = 0; m_prev = vec;
      end else begin
         if (q.size() != 0 && rdy) void'(q.pop_front());
         if (en) begin
            g = -1;
            for (int k = NEV - 1; k >= 0; k--) if (m_pend[k]) g = k;
            nb = vec & ~m_prev;
            m_pend = m_pend | nb;
            if (g >= 0) begin
               e.ts = m_ts; e.idx = g; e.wm = slice_of(g);
               if (q.size() < DEPTH) q.push_back(e);
               else if (m_ovf < 255) m_ovf++;
               m_pend[g] = 1'b0;
            end
            m_prev = vec;
            m_ts   = m_ts + 1;
         end else begin
            m_pend = 0; m_prev = 0;
         end
      end
   endfunction

   task automatic compare_model();
      chk("m_count", 64'(count_o), 64'(q.size()));
      chk("m_valid", 64'(valid_o), 64'(q.size() != 0));
      chk("m_pending", 64'(pending_o), 64'(m_pend != 0));
      chk("m_ovf", 64'(ovf_o), 64'(m_ovf));
      if (q.size() != 0) begin
         chk("m_head_ts", 64'(ts_o), 64'(q[0].ts));
         chk("m_head_idx", 64'(idx_o), 64'(q[0].idx));
         chk("m_head_wm", 64'(wm_o), 64'(q[0].wm));
      end
   endtask

   // One clock: inputs held across the edge, outputs sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   typedef struct {
      bit         clr;
      bit         rdy;
      logic [7:0] vec;
      int         cnt;
      bit         pend;
      int         idx;
      int         ts;
   } row_t;

   row_t tbl[8];

   initial begin
      // Slice k holds 0x22+k, so slice 3 is 0x25
      wm = '0;
      for (int k = 0; k < NEV; k++) wm[k*8 +: 8] = 8'(8'h22 + k);
      rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b0; vec = '0;
      tick(); tick();
      chk("rst_valid", 64'(valid_o), 0);
      chk("rst_count", 64'(count_o), 0);
      chk("rst_ts", 64'(ts_o), 0);
      chk("rst_idx", 64'(idx_o), 0);
      chk("rst_wm", 64'(wm_o), 0);
      chk("rst_ovf", 64'(ovf_o), 0);
      chk("rst_pending", 64'(pending_o), 0);

      // Single event: bit 3 detected at the edge where ts=9, logged at ts=10
      rst = 1'b0; en = 1'b1; rdy = 1'b1;
      repeat (9) tick();
      vec = 8'h08;
      tick();
      chk("s1_pending", 64'(pending_o), 1);
      chk("s1_count0", 64'(count_o), 0);
      tick();
      chk("s1_valid", 64'(valid_o), 1);
      chk("s1_ts", 64'(ts_o), 10);
      chk("s1_idx", 64'(idx_o), 3);
      chk("s1_wm", 64'(wm_o), 8'h25);
      tick();
      chk("s1_popped", 64'(count_o), 0);
      repeat (5) tick();
      chk("s1_no_relog", 64'(count_o), 0);
      chk("s1_no_pend", 64'(pending_o), 0);

      // Table: clear, then bits 0,5,7 rise together with bit 3 still high
      tbl[0] = '{1, 0, 8'h08, 0, 0, -1, 0};
      tbl[1] = '{0, 0, 8'hA9, 0, 1, -1, 0};
      tbl[2] = '{0, 0, 8'hA9, 1, 1,  0, 1};
      tbl[3] = '{0, 0, 8'hA9, 2, 1,  0, 1};
      tbl[4] = '{0, 0, 8'hA9, 3, 0,  0, 1};
      tbl[5] = '{0, 1, 8'hA9, 2, 0,  5, 2};
      tbl[6] = '{0, 1, 8'hA9, 1, 0,  7, 3};
      tbl[7] = '{0, 1, 8'hA9, 0, 0, -1, 0};
      for (int i = 0; i < 8; i++) begin
         clr = tbl[i].clr; rdy = tbl[i].rdy; vec = tbl[i].vec;
         tick();
         chk($sformatf("tbl%0d_count", i), 64'(count_o), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d_pending", i), 64'(pending_o), 64'(tbl[i].pend));
         if (tbl[i].idx >= 0) begin
            chk($sformatf("tbl%0d_idx", i), 64'(idx_o), 64'(tbl[i].idx));
            chk($sformatf("tbl%0d_ts", i), 64'(ts_o), 64'(tbl[i].ts));
            chk($sformatf("tbl%0d_wm", i), 64'(wm_o), 64'(8'h22 + tbl[i].idx));
         end
      end
      clr = 1'b0;

      // Overflow: 8 entries fill the FIFO, 2 more after a disable are dropped
      rdy = 1'b0;
      en = 1'b0; vec = 8'h00; tick();
      en = 1'b1; vec = 8'hFF; tick();
      repeat (8) tick();
      chk("ovf_fill_count", 64'(count_o), 8);
      chk("ovf_fill_ovf", 64'(ovf_o), 0);
      chk("ovf_fill_head", 64'(idx_o), 0);
      en = 1'b0; vec = 8'h00; tick();
      en = 1'b1; vec = 8'h03; tick();
      tick(); tick();
      chk("ovf_count", 64'(count_o), 8);
      chk("ovf_dropped", 64'(ovf_o), 2);
      chk("ovf_pending", 64'(pending_o), 0);
      chk("ovf_head", 64'(idx_o), 0);

      // Full FIFO with a grant and a pop in the same cycle
      en = 1'b0; vec = 8'h00; tick();
      en = 1'b1; vec = 8'h04; tick();
      rdy = 1'b1; tick();
      chk("pp_count", 64'(count_o), 8);
      chk("pp_ovf", 64'(ovf_o), 2);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d_idx", i), 64'(idx_o), 64'((i < 7) ? i + 1 : 2));
         chk($sformatf("drain%0d_wm", i), 64'(wm_o), 64'(8'h22 + ((i < 7) ? i + 1 : 2)));
         tick();
      end
      chk("drain_empty", 64'(count_o), 0);
      tick();
      chk("ready_on_empty", 64'(count_o), 0);
      chk("ready_on_empty_v", 64'(valid_o), 0);

      // Soft clear with bits 0,1 set and a grant in flight
      rdy = 1'b0;
      en = 1'b0; vec = 8'h00; tick();
      en = 1'b1; vec = 8'h03; tick();
      tick();
      chk("clr_pre_count", 64'(count_o), 1);
      clr = 1'b1; tick();
      clr = 1'b0;
      chk("clr_count", 64'(count_o), 0);
      chk("clr_ovf", 64'(ovf_o), 0);
      chk("clr_pending", 64'(pending_o), 0);
      vec = 8'h07; tick(); tick();
      chk("clr_new_count", 64'(count_o), 1);
      chk("clr_new_idx", 64'(idx_o), 2);
      chk("clr_new_ts", 64'(ts_o), 1);
      chk("clr_new_wm", 64'(wm_o), 8'h24);
      repeat (3) tick();
      chk("clr_no_relog", 64'(count_o), 1);

      // Disable keeps entries and freezes ts; bit 1 re-rising logs again
      en = 1'b0; vec = 8'h00;
      repeat (4) tick();
      chk("dis_count", 64'(count_o), 1);
      chk("dis_pending", 64'(pending_o), 0);
      chk("dis_head", 64'(idx_o), 2);
      en = 1'b1; tick();
      vec = 8'h02; tick(); tick();
      chk("dis_new_count", 64'(count_o), 2);
      rdy = 1'b1;
      chk("dis_old_ts", 64'(ts_o), 1);
      tick();
      chk("dis_new_idx", 64'(idx_o), 1);
      chk("dis_new_ts", 64'(ts_o), 7);
      chk("dis_new_wm", 64'(wm_o), 8'h23);
      tick();
      chk("dis_empty", 64'(count_o), 0);

      // Randomized traffic checked against the model every cycle
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom % 600) == 0;
         clr = ($urandom % 97) == 0;
         en  = ($urandom % 20) != 0;
         rdy = ($urandom % 3) == 0;
         if (!en) vec = 8'h00;
         else if (($urandom % 4) == 0) vec = vec | 8'(1 << ($urandom % 8));
         wm  = {$urandom, $urandom};
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
